// File: rtl/regular_sensor_decoder_if.sv
// ---------------------------------------------------------------------------
// regular_sensor_decoder_if
// Bundles the sensor-window control, the slot line, the read port and the
// status outputs of regular_sensor_decoder.
//
// Handshake: there is no valid/ready pair. sample_en is a level request,
// taken only while the decoder is idle (busy=0); done is a one-cycle pulse
// marking the end of a window; rd_addr is accepted every cycle and rd_data
// follows one cycle later.
//
// Signals:
//   sample_en     master->slave  start a sample window
//   slot_in       master->slave  wired-OR of all sensor slot lines
//   rd_addr       master->slave  sensor index to read
//   rd_data       slave->master  registered stored value for rd_addr
//   valid_map     slave->master  bit i = sensor i reported
//   collision_map slave->master  bit i = more than one pulse in slot i
//   busy          slave->master  window in progress
//   done          slave->master  one-cycle pulse at window end
//   fsm_state     slave->master  current FSM state (debug)
// ---------------------------------------------------------------------------
interface regular_sensor_decoder_if #(
    parameter int SLOT_W = 4,
    parameter int DATA_W = 8
);
    logic                     sample_en;
    logic                     slot_in;
    logic [SLOT_W-1:0]        rd_addr;
    logic [DATA_W-1:0]        rd_data;
    logic [(1<<SLOT_W)-1:0]   valid_map;
    logic [(1<<SLOT_W)-1:0]   collision_map;
    logic                     busy;
    logic                     done;
    logic [0:0]               fsm_state;

    modport master (
        output sample_en, slot_in, rd_addr,
        input  rd_data, valid_map, collision_map, busy, done, fsm_state
    );

    modport slave (
        input  sample_en, slot_in, rd_addr,
        output rd_data, valid_map, collision_map, busy, done, fsm_state
    );
endinterface

// File: rtl/regular_sensor_decoder.sv
// ---------------------------------------------------------------------------
// regular_sensor_decoder
// Time-slot sensor decoder. A window of SLOTS*FRAMES cycles is opened by
// sample_en. Each cycle belongs to one slot (cycle mod SLOTS) and one frame
// (cycle div SLOTS). A sensor reports its value by pulsing the shared slot
// line in its own slot during the frame equal to that value; the first pulse
// per slot is stored, further pulses in that slot flag a collision.
//
// Ports:
//   clk_division  single clock, rising edge
//   rst           synchronous, active-high reset
//   bus           regular_sensor_decoder_if.slave (see interface header)
// ---------------------------------------------------------------------------
module regular_sensor_decoder #(
    parameter int SLOT_W = 4,
    parameter int DATA_W = 8
) (
    input logic                     clk_division,
    input logic                     rst,
    regular_sensor_decoder_if.slave bus
);
    localparam int SLOTS = 1 << SLOT_W;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SAMPLE = 1'b1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = '1;
    localparam logic [DATA_W-1:0] FRAME_LAST = '1;

    logic [0:0]        state;
    logic [SLOT_W-1:0] slot_cnt;
    logic [DATA_W-1:0] frame_cnt;
    logic [SLOTS-1:0]  valid_map;
    logic [SLOTS-1:0]  collision_map;
    logic [DATA_W-1:0] values [SLOTS];
    logic [DATA_W-1:0] rd_data;
    logic              done;

    // Last cycle of the window: final slot of the final frame.
    logic last_cycle;
    assign last_cycle = (slot_cnt == SLOT_LAST) && (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk_division) begin
        if (rst) begin
            state         <= IDLE;
            slot_cnt      <= '0;
            frame_cnt     <= '0;
            valid_map     <= '0;
            collision_map <= '0;
            rd_data       <= '0;
            done          <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                values[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            // Read port reads the array as it stood before this edge.
            rd_data <= values[bus.rd_addr];

            case (state)
                IDLE: begin
                    // slot_in is ignored here; results hold until a new start.
                    if (bus.sample_en) begin
                        state         <= SAMPLE;
                        slot_cnt      <= '0;
                        frame_cnt     <= '0;
                        valid_map     <= '0;
                        collision_map <= '0;
                        for (int i = 0; i < SLOTS; i++) begin
                            values[i] <= '0;
                        end
                    end
                end

                SAMPLE: begin
                    // First pulse in a slot wins; later ones only mark a collision.
                    if (bus.slot_in) begin
                        if (!valid_map[slot_cnt]) begin
                            values[slot_cnt]    <= frame_cnt;
                            valid_map[slot_cnt] <= 1'b1;
                        end else begin
                            collision_map[slot_cnt] <= 1'b1;
                        end
                    end

                    slot_cnt <= slot_cnt + 1'b1;
                    if (slot_cnt == SLOT_LAST) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end

                    if (last_cycle) begin
                        state     <= IDLE;
                        slot_cnt  <= '0;
                        frame_cnt <= '0;
                        done      <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data       = rd_data;
    assign bus.valid_map     = valid_map;
    assign bus.collision_map = collision_map;
    assign bus.busy          = (state == SAMPLE);
    assign bus.done          = done;
    assign bus.fsm_state     = state;
endmodule
